uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Framed command decoder between the UART receiver (byte + data-valid strobe) and the waveform mode/frequency logic.
- Assembles multi-byte frames, validates them, and drives the registered `mode` select and 16-bit `factor` consumed by the sine-rate generator.
- Replaces ad-hoc per-byte decoding with a single protocol:
  - header 0xA5, cmd, data_hi, data_lo, optional checksum.
  - Includes inter-byte timeout and error reporting.

Parameters:
- TIMEOUT_CYCLES, 100000, clk cycles allowed between bytes inside a frame (1 ms at 100 MHz); minimum 2.
- HEADER, 8'hA5, frame start byte.
- MODE_RST, 3'b001, mode after reset (timer555 source).
- FACTOR_RST, 16'd1, factor after reset.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- rx_byte  input  8  received UART byte; valid only when rx_dv=1.
- rx_dv  input  1  one-cycle strobe, byte valid.
- mode  output  3  waveform clock source select: 3'b001 = timer555, 3'b010 = sine/factor.
- factor  output  16  frequency division factor.
- factor_valid  output  1  one-cycle pulse when factor updated.
- err  output  1  one-cycle pulse on a rejected or aborted frame.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset: synchronous, active-high; clk and rst as named above.
  - Values: state=IDLE, mode=MODE_RST, factor=FACTOR_RST, factor_valid=0, err=0, busy=0, timeout counter=0.
  - Reset mid-frame discards the partial frame with no err pulse.
- FSM states: IDLE -> CMD -> DHI -> DLO -> [CHK] -> IDLE. Transitions occur only on rx_dv=1, except timeout.
  - IDLE: rx_byte==HEADER -> CMD. Any other byte is ignored silently (no err).
  - CMD: latch cmd -> DHI.
  - DHI: latch data_hi -> DLO.
  - DLO: latch data_lo -> CHK if CMD_CHECKSUM_EN, else execute and return to IDLE.
  - CHK: compare byte, execute, return to IDLE.
- Inside a frame, HEADER is treated as ordinary data; there is no resync.
- Execute happens on the posedge that samples the final byte's rx_dv, so outputs change 1 cycle after that rx_dv.
  - cmd 0x4D ('M'): data_lo[2:0] must be 3'b001 or 3'b010 -> mode updated. Any other value -> err, mode unchanged. data_hi is ignored.
  - cmd 0x46 ('F'): {data_hi,data_lo}!=0 -> factor updated and factor_valid=1 in the same cycle. Value 0 -> err, factor unchanged.
  - Any other cmd: the full frame is still consumed, then err; no output change.
- Timeout:
  - A counter clears on each accepted rx_dv and increments every cycle while state != IDLE.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_dv that cycle: err pulse, state -> IDLE.
  - rx_dv arriving in the expiry cycle wins: the byte is accepted and the counter clears.
  - The counter saturates and never wraps.
- err and factor_valid are mutually exclusive; each is high for exactly one cycle.
- Back-to-back frames are allowed: a header on the cycle after execute is accepted.

Optional Feature:
- CMD_CHECKSUM_EN defined:
  - Frames are 5 bytes; CHK state present.
  - Checksum = cmd ^ data_hi ^ data_lo.
  - Mismatch -> err, no execute.
- CMD_CHECKSUM_EN undefined:
  - Frames are 4 bytes; no CHK state.
  - Execute on the data_lo byte.

Decomposition:
- Shared package `waveform_pkg`:
  - Parser state enum.
  - Constants CMD_MODE=8'h4D, CMD_FACTOR=8'h46, MODE_TIMER=3'b001, MODE_SINE=3'b010.
  - Also used by the mode consumers.
- One natural sub-module: `cmd_timeout`, a saturating counter with clear, enable and expired outputs, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Reset, then the frame A5 46 01 2C (+chk 6B if enabled) at 1 byte/10 cycles -> factor=16'h012C and factor_valid=1 for 1 cycle, 1 cycle after the last rx_dv; err=0.
- Frame A5 4D 00 02 (+chk 4F) -> mode=3'b010. Then A5 4D 00 05 (+chk 48) -> err pulse, mode stays 3'b010.
- Frame A5 46 00 00 (+chk 46) -> err pulse; factor keeps its previous value; factor_valid stays 0.
- Garbage 00 FF 13 then A5 46 00 10 (+chk 56) -> no err for the garbage; factor=16'h0010.
- A5 46, then a gap of TIMEOUT_CYCLES -> err pulse, busy=0. The next frame parses normally. Repeat with rx_dv exactly in the expiry cycle -> no err, byte accepted.
- rst asserted after A5 46 01 -> outputs at reset values, no err. A full frame after rst deasserts parses correctly. With CMD_CHECKSUM_EN, a wrong checksum byte -> err, no update.

Source files
------------

// File: rtl/waveform_pkg.sv
// Shared types and constants for the waveform mode/frequency path.
// Used by uart_cmd_parser and by the mode consumers downstream.
package waveform_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_DHI  = 3'd2,
        S_DLO  = 3'd3,
        S_CHK  = 3'd4
    } parser_state_e;

    localparam logic [7:0] CMD_MODE   = 8'h4D;
    localparam logic [7:0] CMD_FACTOR = 8'h46;
    localparam logic [2:0] MODE_TIMER = 3'b001;
    localparam logic [2:0] MODE_SINE  = 3'b010;

    // Checksum byte carried at the end of a frame when checksums are enabled
    function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                             input logic [7:0] dhi,
                                             input logic [7:0] dlo);
        return cmd ^ dhi ^ dlo;
    endfunction

endpackage

// File: rtl/cmd_timeout.sv
// Saturating inter-byte timeout counter: clears on i_clr, counts while i_en,
// o_expired_c flags the last allowed cycle of a gap.
module cmd_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired_c
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Holds at LAST instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired_c = i_en && (r_cnt == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Framed UART command decoder driving waveform mode and sine-rate factor.
// Build option: define CMD_CHECKSUM_EN for 5-byte frames with an XOR checksum.
module uart_cmd_parser
    import waveform_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  HEADER         = 8'hA5,
    parameter logic [2:0]  MODE_RST       = 3'b001,
    parameter logic [15:0] FACTOR_RST     = 16'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_dv,
    output logic [2:0]  mode,
    output logic [15:0] factor,
    output logic        factor_valid,
    output logic        err,
    output logic        busy
);

    parser_state_e r_state;
    parser_state_e w_state_nxt;
    logic [7:0]    r_cmd;
    logic [7:0]    r_dhi;
    logic [7:0]    r_dlo;
    logic [7:0]    w_cmd_nxt;
    logic [7:0]    w_dhi_nxt;
    logic [7:0]    w_dlo_nxt;
    logic [2:0]    w_mode_nxt;
    logic [15:0]   w_factor_nxt;
    logic          w_fv_nxt;
    logic          w_err_nxt;
    logic          w_exec;
    logic [7:0]    w_exec_dlo;
    logic          w_expired;
    logic          w_timeout;

    cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (rx_dv || (r_state == S_IDLE)),
        .i_en       (r_state != S_IDLE),
        .o_expired_c(w_expired)
    );

    // A byte landing in the expiry cycle wins over the timeout
    assign w_timeout = w_expired && !rx_dv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cmd        <= '0;
            r_dhi        <= '0;
            r_dlo        <= '0;
            mode         <= MODE_RST;
            factor       <= FACTOR_RST;
            factor_valid <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cmd        <= w_cmd_nxt;
            r_dhi        <= w_dhi_nxt;
            r_dlo        <= w_dlo_nxt;
            mode         <= w_mode_nxt;
            factor       <= w_factor_nxt;
            factor_valid <= w_fv_nxt;
            err          <= w_err_nxt;
            busy         <= (w_state_nxt != S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cmd_nxt    = r_cmd;
        w_dhi_nxt    = r_dhi;
        w_dlo_nxt    = r_dlo;
        w_mode_nxt   = mode;
        w_factor_nxt = factor;
        w_fv_nxt     = 1'b0;
        w_err_nxt    = 1'b0;
        w_exec       = 1'b0;
        w_exec_dlo   = r_dlo;

        case (r_state)
            S_IDLE: begin
                if (rx_dv && (rx_byte == HEADER)) w_state_nxt = S_CMD;
            end
            S_CMD: begin
                if (rx_dv) begin
                    w_cmd_nxt   = rx_byte;
                    w_state_nxt = S_DHI;
                end
            end
            S_DHI: begin
                if (rx_dv) begin
                    w_dhi_nxt   = rx_byte;
                    w_state_nxt = S_DLO;
                end
            end
            S_DLO: begin
                if (rx_dv) begin
                    w_dlo_nxt   = rx_byte;
`ifdef CMD_CHECKSUM_EN
                    w_state_nxt = S_CHK;
`else
                    w_state_nxt = S_IDLE;
                    w_exec      = 1'b1;
                    w_exec_dlo  = rx_byte;
`endif
                end
            end
            S_CHK: begin
`ifdef CMD_CHECKSUM_EN
                if (rx_dv) begin
                    w_state_nxt = S_IDLE;
                    if (rx_byte == frame_chk(r_cmd, r_dhi, r_dlo)) w_exec = 1'b1;
                    else                                           w_err_nxt = 1'b1;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
        end

        // Execute the completed frame; any rejection leaves outputs untouched
        if (w_exec) begin
            case (r_cmd)
                CMD_MODE: begin
                    if ((w_exec_dlo[2:0] == MODE_TIMER) || (w_exec_dlo[2:0] == MODE_SINE))
                        w_mode_nxt = w_exec_dlo[2:0];
                    else
                        w_err_nxt = 1'b1;
                end
                CMD_FACTOR: begin
                    if ({r_dhi, w_exec_dlo} != 16'd0) begin
                        w_factor_nxt = {r_dhi, w_exec_dlo};
                        w_fv_nxt     = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                default: w_err_nxt = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser (either checksum build).
`timescale 1ns/1ps
module tb_uart_cmd_parser;

    localparam int unsigned TO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_dv;
    logic [2:0]  mode;
    logic [15:0] factor;
    logic        factor_valid;
    logic        err;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    uart_cmd_parser #(
        .TIMEOUT_CYCLES(TO),
        .HEADER        (8'hA5),
        .MODE_RST      (3'b001),
        .FACTOR_RST    (16'd1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_byte     (rx_byte),
        .rx_dv       (rx_dv),
        .mode        (mode),
        .factor      (factor),
        .factor_valid(factor_valid),
        .err         (err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // All drivers start and end at a falling edge
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_dv   = 1'b1;
        @(negedge clk);
        rx_dv   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                              input int gap, input bit good_chk);
        send_byte(8'hA5); idle(gap);
        send_byte(c);     idle(gap);
        send_byte(h);     idle(gap);
`ifdef CMD_CHECKSUM_EN
        send_byte(l);     idle(gap);
        send_byte(good_chk ? (c ^ h ^ l) : ~(c ^ h ^ l));
`else
        send_byte(l);
        if (!good_chk) n_checks += 0;
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        idle(3);
        check("rst_mode",   32'(mode),         32'h1);
        check("rst_factor", 32'(factor),       32'h1);
        check("rst_fv",     32'(factor_valid), 32'h0);
        check("rst_err",    32'(err),          32'h0);
        check("rst_busy",   32'(busy),         32'h0);
        rst = 1'b0;
        idle(2);

        // Factor frame at 1 byte / 10 cycles
        send_byte(8'hA5);
        check("busy_hdr", 32'(busy), 32'h1);
        idle(9);
        send_byte(8'h46); idle(9);
        send_byte(8'h01); idle(9);
`ifdef CMD_CHECKSUM_EN
        send_byte(8'h2C); idle(9);
        send_byte(8'h6B);
`else
        send_byte(8'h2C);
`endif
        check("f_factor", 32'(factor),       32'h012C);
        check("f_fv",     32'(factor_valid), 32'h1);
        check("f_err",    32'(err),          32'h0);
        check("f_busy",   32'(busy),         32'h0);
        idle(1);
        check("f_fv_end", 32'(factor_valid), 32'h0);

        // Mode select, then an illegal mode
        send_frame(8'h4D, 8'h00, 8'h02, 9, 1'b1);
        check("m_mode", 32'(mode), 32'h2);
        check("m_err",  32'(err),  32'h0);
        idle(3);
        send_frame(8'h4D, 8'h00, 8'h05, 9, 1'b1);
        check("mbad_err",  32'(err),  32'h1);
        check("mbad_mode", 32'(mode), 32'h2);
        idle(1);
        check("mbad_err_end", 32'(err), 32'h0);

        // Zero factor is rejected
        send_frame(8'h46, 8'h00, 8'h00, 9, 1'b1);
        check("fz_err",    32'(err),          32'h1);
        check("fz_fv",     32'(factor_valid), 32'h0);
        check("fz_factor", 32'(factor),       32'h012C);
        idle(3);

        // Unknown command consumes a full frame then errors
        send_frame(8'h55, 8'h12, 8'h34, 2, 1'b1);
        check("unk_err",    32'(err),    32'h1);
        check("unk_factor", 32'(factor), 32'h012C);
        check("unk_mode",   32'(mode),   32'h2);
        idle(3);

        // Garbage before a header is silently ignored
        send_byte(8'h00); idle(1); check("g0_err", 32'(err), 32'h0);
        send_byte(8'hFF); idle(1); check("g1_err", 32'(err), 32'h0);
        send_byte(8'h13); idle(1); check("g2_err", 32'(err), 32'h0);
        check("g_busy", 32'(busy), 32'h0);
        send_frame(8'h46, 8'h00, 8'h10, 9, 1'b1);
        check("g_factor", 32'(factor),       32'h0010);
        check("g_fv",     32'(factor_valid), 32'h1);
        idle(3);

        // Inter-byte timeout: err lands TO cycles after the last byte
        send_byte(8'hA5); idle(2);
        send_byte(8'h46);
        idle(TO - 1);
        check("to_pre_err",  32'(err),  32'h0);
        check("to_pre_busy", 32'(busy), 32'h1);
        idle(1);
        check("to_err",  32'(err),  32'h1);
        check("to_busy", 32'(busy), 32'h0);
        idle(1);
        send_frame(8'h46, 8'h00, 8'h20, 3, 1'b1);
        check("to_next_factor", 32'(factor), 32'h0020);

        // Byte arriving in the expiry cycle is accepted
        idle(2);
        send_byte(8'hA5); idle(2);
        send_byte(8'h46);
        idle(TO - 1);
        send_byte(8'h00);
        check("exp_err",  32'(err),  32'h0);
        check("exp_busy", 32'(busy), 32'h1);
        idle(3);
`ifdef CMD_CHECKSUM_EN
        send_byte(8'h30); idle(3);
        send_byte(8'h76);
`else
        send_byte(8'h30);
`endif
        check("exp_factor", 32'(factor), 32'h0030);
        check("exp_fv",     32'(factor_valid), 32'h1);

        // Back-to-back frames with no idle cycles
        send_frame(8'h46, 8'h00, 8'h40, 0, 1'b1);
        check("b2b_f1", 32'(factor), 32'h0040);
        send_frame(8'h46, 8'h00, 8'h41, 0, 1'b1);
        check("b2b_f2",  32'(factor),       32'h0041);
        check("b2b_fv2", 32'(factor_valid), 32'h1);
        idle(3);

        // Reset mid-frame drops the partial frame without err
        send_byte(8'hA5); idle(1);
        send_byte(8'h46); idle(1);
        send_byte(8'h01);
        rst = 1'b1;
        idle(1);
        check("mr_err1", 32'(err), 32'h0);
        idle(1);
        check("mr_err2",    32'(err),    32'h0);
        check("mr_mode",    32'(mode),   32'h1);
        check("mr_factor",  32'(factor), 32'h1);
        check("mr_busy",    32'(busy),   32'h0);
        rst = 1'b0;
        idle(1);
        check("mr_err3", 32'(err), 32'h0);
        send_frame(8'h46, 8'h01, 8'h2C, 9, 1'b1);
        check("mr_factor2", 32'(factor), 32'h012C);
        check("mr_fv",      32'(factor_valid), 32'h1);

`ifdef CMD_CHECKSUM_EN
        idle(3);
        send_frame(8'h46, 8'h00, 8'h99, 2, 1'b0);
        check("chk_err",    32'(err),          32'h1);
        check("chk_fv",     32'(factor_valid), 32'h0);
        check("chk_factor", 32'(factor),       32'h012C);
`endif

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
